// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M-style multiply/divide unit, generalised to XLEN.
// A radix-2 shift-add multiplier and a restoring divider share one datapath
// (hi_reg:lo_reg pair plus an operand register). The result is held until the
// consumer takes it.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   flush                 synchronous abort back to IDLE, discards any result
//   in_valid / in_ready   request handshake (in_ready high only in IDLE)
//   in_op                 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   in_src1, in_src2      rs1 (multiplicand/dividend), rs2 (multiplier/divisor)
//   out_valid / out_ready result handshake
//   out_result, out_zero  result and its zero flag, valid with out_valid
module alu_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [2:0]        op_reg;
  logic [XLEN-1:0]   hi_reg;
  logic [XLEN-1:0]   lo_reg;
  logic [XLEN-1:0]   opd_reg;
  logic              neg_q_reg;   // product / quotient must be negated
  logic              neg_r_reg;   // remainder must be negated (dividend sign)
  logic              out_valid_reg;
  logic [XLEN-1:0]   out_result_reg;
  logic              out_zero_reg;

  // ---------------- accept-time operand preparation ----------------
  logic            s1_signed, s2_signed, neg1, neg2;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_by_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  always_comb begin
    s1_signed   = in_op[2] ? ~in_op[0] : (in_op[1:0] != 2'd3);
    s2_signed   = in_op[2] ? ~in_op[0] : ~in_op[1];
    neg1        = s1_signed & in_src1[XLEN-1];
    neg2        = s2_signed & in_src2[XLEN-1];
    // Negating the most negative value yields 2^(XLEN-1), correct as unsigned.
    mag1        = neg1 ? (~in_src1 + 1'b1) : in_src1;
    mag2        = neg2 ? (~in_src2 + 1'b1) : in_src2;
    div_by_zero = in_op[2] & (in_src2 == '0);
    div_ovf     = in_op[2] & ~in_op[0] & (in_src1 == {1'b1, {(XLEN-1){1'b0}}}) & (&in_src2);
    special     = div_by_zero | div_ovf;
    special_res = '0;
    if (div_by_zero)
      special_res = in_op[1] ? in_src1 : '1;
    else if (div_ovf)
      special_res = in_op[1] ? '0 : in_src1;
  end

  // ---------------- one iteration of the shared datapath ----------------
  logic [XLEN-1:0] addend;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic            div_ok;
  logic [XLEN-1:0] div_rem;
  logic [XLEN-1:0] hi_next, lo_next;

  always_comb begin
    // Multiply: add multiplicand when the multiplier LSB is set, then shift
    // the whole {carry,hi,lo} right one place.
    addend    = lo_reg[0] ? opd_reg : '0;
    mul_sum   = {1'b0, hi_reg} + {1'b0, addend};
    // Divide: shift {rem,quo} left one place, keep the trial difference only
    // if it did not go negative. The remainder is always below the divisor,
    // so the shifted value fits in XLEN+1 bits and the difference in XLEN.
    div_shift = {hi_reg, lo_reg[XLEN-1]};
    div_ok    = (div_shift >= {1'b0, opd_reg});
    div_rem   = div_shift[XLEN-1:0] - opd_reg;
    if (op_reg[2]) begin
      hi_next = div_ok ? div_rem : div_shift[XLEN-1:0];
      lo_next = {lo_reg[XLEN-2:0], div_ok};
    end else begin
      hi_next = mul_sum[XLEN:1];
      lo_next = {mul_sum[0], lo_reg[XLEN-1:1]};
    end
  end

  // ---------------- sign correction and result select ----------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  always_comb begin
    prod_fix = neg_q_reg ? (~{hi_reg, lo_reg} + 1'b1) : {hi_reg, lo_reg};
    quo_fix  = neg_q_reg ? (~lo_reg + 1'b1) : lo_reg;
    rem_fix  = neg_r_reg ? (~hi_reg + 1'b1) : hi_reg;
    case (op_reg)
      3'd0:         fix_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:         fix_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:   fix_res = quo_fix;
      default:      fix_res = rem_fix;
    endcase
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      op_reg         <= '0;
      hi_reg         <= '0;
      lo_reg         <= '0;
      opd_reg        <= '0;
      neg_q_reg      <= 1'b0;
      neg_r_reg      <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_result_reg <= '0;
      out_zero_reg   <= 1'b1;
    end else if (flush) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            op_reg    <= in_op;
            cnt_reg   <= '0;
            neg_q_reg <= neg1 ^ neg2;
            neg_r_reg <= neg1;
            hi_reg    <= '0;
            lo_reg    <= in_op[2] ? mag1 : mag2;
            opd_reg   <= in_op[2] ? mag2 : mag1;
            if (special) begin
              // Result is known now; DONE raises out_valid on its first cycle.
              out_result_reg <= special_res;
              out_zero_reg   <= (special_res == '0);
              state_reg      <= S_DONE;
            end else begin
              state_reg <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (cnt_reg == CNT_W'(XLEN)) begin
            state_reg <= S_FIX;
          end else begin
            hi_reg  <= hi_next;
            lo_reg  <= lo_next;
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        S_FIX: begin
          out_result_reg <= fix_res;
          out_zero_reg   <= (fix_res == '0);
          out_valid_reg  <= 1'b1;
          state_reg      <= S_DONE;
        end
        S_DONE: begin
          if (!out_valid_reg) begin
            out_valid_reg <= 1'b1;
          end else if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (state_reg == S_IDLE);
  assign out_valid  = out_valid_reg;
  assign out_result = out_result_reg;
  assign out_zero   = out_zero_reg;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (XLEN=32): directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_alu_muldiv;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [XLEN-1:0] in_src1;
  logic [XLEN-1:0] in_src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            out_zero;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_result = '0;

  alu_muldiv #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: RV32M semantics with plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == MIN_INT && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 2;
  endfunction

  // Drive a request for one edge; called #1 after a rising edge.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = 3'($urandom); in_src1 = $urandom; in_src2 = $urandom;
  endtask

  // Full transaction: accept, wait, check latency/result, hold, handshake.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit poke);
    logic [31:0] exp_res;
    int cyc;
    exp_res = ref_model(op, a, b);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    start_op(op, a, b);
    cyc = 0;
    while (!out_valid && cyc < 60) begin
      if (poke && cyc == 3) begin in_valid = 1'b1; in_src2 = 32'h0; end
      if (cyc == 4) in_valid = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("latency", 64'(cyc), 64'(ref_latency(op, a, b)));
    chk("result", 64'(out_result), 64'(exp_res));
    chk("zero", 64'(out_zero), 64'(exp_res == 0));
    chk("in_ready_busy", 64'(in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_result", 64'(out_result), 64'(exp_res));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("after_hs_valid", 64'(out_valid), 64'd0);
    chk("after_hs_in_ready", 64'(in_ready), 64'd1);
    last_result = exp_res;
    $display("op=%0d a=%h b=%h result=%h exp=%h lat=%0d", op, a, b, out_result, exp_res, cyc);
  endtask

  // Wait n cycles and check out_valid never rose.
  task automatic expect_quiet(input string tag, input int n);
    bit seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return MIN_INT;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_src1 = '0; in_src2 = '0;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(out_result), 64'd0);
    chk("rst_zero", 64'(out_zero), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_op(3'd0, 32'd7, 32'd6, 0, 0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(3'd5, 32'd100, 32'd7, 0, 0);
    run_op(3'd7, 32'd100, 32'd7, 0, 0);
    run_op(3'd4, 32'd1234, 32'd0, 0, 0);
    run_op(3'd6, 32'd5, 32'd0, 0, 0);
    run_op(3'd4, MIN_INT, 32'hFFFF_FFFF, 0, 0);
    run_op(3'd6, MIN_INT, 32'hFFFF_FFFF, 0, 0);
    run_op(3'd0, 32'd0, 32'hDEAD_BEEF, 0, 0);
    run_op(3'd5, 32'd9, 32'd0, 3, 0);
    run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 10, 1);

    // flush mid-CALC
    start_op(3'd0, 32'd123, 32'd456);
    repeat (15) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_keeps_result", 64'(out_result), 64'(last_result));
    expect_quiet("flush_quiet", 40);

    // flush together with in_valid in IDLE: no accept
    in_valid = 1'b1; flush = 1'b1; in_op = 3'd0; in_src1 = 32'd3; in_src2 = 32'd3;
    @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_in_ready", 64'(in_ready), 64'd1);
    expect_quiet("flush_idle_quiet", 40);
    run_op(3'd0, 32'd11, 32'd13, 0, 0);

    // flush and out_ready in same DONE cycle
    start_op(3'd5, 32'd77, 32'd0);
    @(posedge clk); #1;
    chk("special_valid", 64'(out_valid), 64'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; flush = 1'b0; out_ready = 1'b0;
    chk("flush_done_valid", 64'(out_valid), 64'd0);
    chk("flush_done_in_ready", 64'(in_ready), 64'd1);

    // async reset mid-CALC
    start_op(3'd4, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_result", 64'(out_result), 64'd0);
    chk("arst_zero", 64'(out_zero), 64'd1);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1; rst_n = 1'b1;
    expect_quiet("arst_quiet", 40);
    run_op(3'd6, 32'hFFFF_FF9C, 32'd7, 0, 0);

    // Randomized operations
    for (int i = 0; i < 50; i++) begin
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
             $urandom_range(0, 2), bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
